// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states and constants for the FIR BRAM engine
package fir_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_IN,
        S_WRITE,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;
    localparam int NUM_TAP_DEF = 11;
    localparam int ADDR_SHIFT  = 2;
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate; product and running sum wrap modulo 2^DATA_W
module fir_mac #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_acc
);
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] r_acc;
    assign w_prod = DATA_W'($signed(i_a) * $signed(i_b));
    // clear wins over enable so a new result never inherits the previous sum
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_prod;
    end
    assign o_acc = r_acc;
endmodule

// File: rtl/fir_bram_engine.sv
// fir_bram_engine: streaming FIR filter with taps and sample history held in external BRAMs
module fir_bram_engine
    import fir_pkg::*;
#(
    parameter int NUM_TAP = NUM_TAP_DEF,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [3:0]        tap_WE,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              data_EN,
    output logic [3:0]        data_WE,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do
);
    localparam int IDX_W = $clog2(NUM_TAP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAP - 1);
    localparam logic [IDX_W-1:0] TAP_CNT  = IDX_W'(NUM_TAP);

    state_t            r_state;
    logic [31:0]       r_len;
    logic [31:0]       r_cnt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_didx;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] w_acc;
    logic              w_last;
    logic              w_mac;
    logic              w_wr;

    assign w_last = (r_cnt + 32'd1) == r_len;
    assign w_mac  = r_state == S_MAC;
    assign w_wr   = (r_state == S_INIT) || (r_state == S_WRITE);

    // frame sequencer: r_idx walks buffer words in INIT and tap slots in MAC,
    // r_didx walks the sample history backwards from the newest word
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_didx   <= '0;
            r_idx    <= '0;
            r_sample <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (ap_start) begin
                    r_state <= S_INIT;
                    r_len   <= data_length;
                    r_cnt   <= '0;
                    r_ptr   <= '0;
                    r_idx   <= '0;
                end
                S_INIT: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= (r_len == 32'd0) ? S_DONE : S_WAIT_IN;
                    end
                end
                S_WAIT_IN: if (ss_tvalid) begin
                    r_sample <= ss_tdata;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_idx   <= '0;
                    r_didx  <= r_ptr;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_idx  <= r_idx + IDX_W'(1);
                    r_didx <= (r_didx == '0) ? LAST_IDX : r_didx - IDX_W'(1);
                    if (r_idx == TAP_CNT)
                        r_state <= S_OUT;
                end
                S_OUT: if (sm_tready) begin
                    r_ptr   <= (r_ptr == LAST_IDX) ? '0 : r_ptr + IDX_W'(1);
                    r_cnt   <= r_cnt + 32'd1;
                    r_state <= w_last ? S_DONE : S_WAIT_IN;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // products arrive one cycle after their addresses, so the first MAC cycle only issues reads
    fir_mac #(.DATA_W(DATA_W)) u_mac (
        .i_clk   (axis_clk),
        .i_rst_n (axis_rst_n),
        .i_clear (r_state == S_WRITE),
        .i_en    (w_mac && (r_idx != '0)),
        .i_a     (tap_Do),
        .i_b     (data_Do),
        .o_acc   (w_acc)
    );

    assign ap_idle   = r_state == S_IDLE;
    assign ap_done   = r_state == S_DONE;
    assign ss_tready = r_state == S_WAIT_IN;
    assign sm_tvalid = r_state == S_OUT;
    assign sm_tdata  = sm_tvalid ? w_acc : '0;
    assign sm_tlast  = sm_tvalid && w_last;
    assign tap_EN    = w_mac;
    assign tap_WE    = 4'h0;
    assign tap_A     = w_mac ? (ADDR_W'(r_idx) << ADDR_SHIFT) : '0;
    assign data_EN   = w_mac || w_wr;
    assign data_WE   = w_wr ? 4'hF : 4'h0;
    assign data_Di   = (r_state == S_WRITE) ? r_sample : '0;
    assign data_A    = (r_state == S_INIT)  ? (ADDR_W'(r_idx)  << ADDR_SHIFT) :
                       (r_state == S_WRITE) ? (ADDR_W'(r_ptr)  << ADDR_SHIFT) :
                       w_mac                ? (ADDR_W'(r_didx) << ADDR_SHIFT) : '0;
endmodule

// File: tb/tb_fir_bram_engine.sv
// tb_fir_bram_engine: random and directed frames checked against a convolution model
module tb_fir_bram_engine;
    localparam int N = 11;

    logic        axis_clk = 0;
    logic        axis_rst_n = 0;
    logic        ap_start = 0;
    logic [31:0] data_length = 0;
    logic        ap_idle, ap_done;
    logic        ss_tvalid = 0;
    logic [31:0] ss_tdata = 0;
    logic        ss_tready;
    logic        sm_tvalid, sm_tlast;
    logic [31:0] sm_tdata;
    logic        sm_tready = 0;
    logic        tap_EN, data_EN;
    logic [3:0]  tap_WE, data_WE;
    logic [11:0] tap_A, data_A;
    logic [31:0] tap_Do, data_Do, data_Di;

    int checks = 0;
    int errors = 0;
    logic [31:0] tap_mem [N];
    logic [31:0] data_mem [N];
    logic [31:0] q_in [$];
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic [31:0] got [$];
    int vprob = 100, rprob = 100, hold = 0, done_cnt = 0, stall_cnt = 0;
    bit drv_en = 0, scramble = 0, prev_done = 0;

    fir_bram_engine dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .ap_start(ap_start),
        .data_length(data_length), .ap_idle(ap_idle), .ap_done(ap_done),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    // BRAM models: one-cycle read latency, read-old on write
    always @(posedge axis_clk) begin
        if (scramble) begin
            foreach (data_mem[i]) data_mem[i] <= $urandom;
        end else begin
            if (tap_EN && int'(tap_A >> 2) < N) tap_Do <= tap_mem[tap_A >> 2];
            if (data_EN && int'(data_A >> 2) < N) begin
                data_Do <= data_mem[data_A >> 2];
                if (data_WE == 4'hF) data_mem[data_A >> 2] <= data_Di;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // y[n] = sum_i tap[i]*x[n-i], x[<0] = 0, everything modulo 2^32
    task automatic model(input logic [31:0] xs[$], input int len);
        for (int n = 0; n < len; n++) begin
            logic [31:0] acc;
            acc = 0;
            for (int i = 0; i < N && i <= n; i++) acc += tap_mem[i] * xs[n-i];
            exp_d.push_back(acc);
            exp_l.push_back(n == len - 1);
        end
    endtask

    // compare outputs every cycle, then drive the next stream inputs
    initial forever begin
        @(negedge axis_clk);
        if (ap_done) begin
            done_cnt++;
            chk("done_pulse", 32'(prev_done), 0);
        end
        prev_done = ap_done;
        chk("tap_we", 32'(tap_WE), 0);
        chk("data_we_shape", 32'(data_WE == 4'h0 || (data_WE == 4'hF && data_EN)), 1);
        if (sm_tvalid) begin
            chk("out_quiet", {29'd0, ss_tready, tap_EN, data_EN}, 0);
            if (exp_d.size() == 0) chk("unexpected_out", 0, 1);
            else begin
                chk("out_data", sm_tdata, exp_d[0]);
                chk("out_last", 32'(sm_tlast), 32'(exp_l[0]));
            end
        end
        if (drv_en) begin
            sm_tready = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < rprob);
            if (sm_tvalid && hold > 0) hold--;
            if (sm_tvalid && !sm_tready) stall_cnt++;
            if (sm_tvalid && sm_tready) begin
                got.push_back(sm_tdata);
                if (exp_d.size() > 0) begin
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            if (q_in.size() > 0 && $urandom_range(0, 99) < vprob) begin
                ss_tvalid = 1;
                ss_tdata  = q_in[0];
                if (ss_tready) void'(q_in.pop_front());
            end else ss_tvalid = 0;
        end else begin
            sm_tready = 0;
            ss_tvalid = 0;
        end
    end

    task automatic chk_reset_outs(input string name);
        chk({name, "_idle"}, 32'(ap_idle), 1);
        chk({name, "_flags"}, {21'd0, ap_done, ss_tready, sm_tvalid, sm_tlast, tap_EN, data_EN, tap_WE[0], data_WE}, 0);
        chk({name, "_tdata"}, sm_tdata, 0);
        chk({name, "_addr"}, {8'd0, tap_A, data_A}, 0);
        chk({name, "_di"}, data_Di, 0);
    endtask

    task automatic run_frame(input string name, input logic [31:0] xs[$], input int len, input bit noise);
        int d0;
        bit ok;
        model(xs, len);
        got.delete();
        q_in = xs;
        drv_en = 1;
        d0 = done_cnt;
        @(negedge axis_clk);
        data_length = len;
        ap_start = 1;
        @(negedge axis_clk);
        ap_start = 0;
        ok = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge axis_clk);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            ap_start = noise && !ap_idle && !ap_done && ($urandom_range(0, 3) == 0);
            if (noise && !ap_idle) data_length = $urandom;
        end
        ap_start = 0;
        chk({name, "_done"}, 32'(ok), 1);
        repeat (3) @(negedge axis_clk);
        chk({name, "_done_count"}, 32'(done_cnt - d0), 1);
        chk({name, "_exp_left"}, 32'(exp_d.size()), 0);
        chk({name, "_in_left"}, 32'(q_in.size()), 0);
        chk({name, "_idle_after"}, 32'(ap_idle), 1);
    endtask

    task automatic directed(input string name, input logic [31:0] xs[$], input logic [31:0] lit[$]);
        exp_d.delete();
        exp_l.delete();
        model(xs, xs.size());
        chk({name, "_model_len"}, 32'(exp_d.size()), 32'(lit.size()));
        foreach (lit[i]) if (i < exp_d.size()) chk({name, "_model"}, exp_d[i], lit[i]);
        if (exp_l.size() > 0) chk({name, "_model_last"}, 32'(exp_l[exp_l.size()-1]), 1);
        exp_d.delete();
        exp_l.delete();
        run_frame(name, xs, xs.size(), 0);
        chk({name, "_out_count"}, 32'(got.size()), 32'(lit.size()));
        foreach (lit[i]) if (i < got.size()) chk({name, "_lit"}, got[i], lit[i]);
    endtask

    task automatic set_taps(input logic [31:0] v);
        foreach (tap_mem[i]) tap_mem[i] = v;
    endtask

    initial begin
        logic [31:0] xs [$];
        logic [31:0] lit [$];
        logic [31:0] s;
        bit ok;
        int len;
        axis_rst_n = 0;
        scramble = 1;
        set_taps(0);
        repeat (3) @(negedge axis_clk);
        scramble = 0;
        chk_reset_outs("reset");
        axis_rst_n = 1;
        @(negedge axis_clk);

        set_taps(1);
        xs.delete(); lit.delete(); s = 0;
        for (int i = 1; i <= 5; i++) begin
            xs.push_back(i);
            s += i;
            lit.push_back(s);
        end
        directed("ramp_sum", xs, lit);

        foreach (tap_mem[i]) tap_mem[i] = i;
        xs.delete(); lit.delete();
        xs.push_back(1);
        for (int i = 0; i < 10; i++) xs.push_back(0);
        for (int i = 0; i < 11; i++) lit.push_back(i);
        directed("impulse", xs, lit);

        set_taps(1);
        xs.delete(); lit.delete();
        for (int i = 0; i < 13; i++) begin
            xs.push_back(1);
            lit.push_back((i < 11) ? i + 1 : 11);
        end
        directed("ptr_wrap", xs, lit);

        set_taps(0);
        tap_mem[0] = 32'hFFFF_FFFF;
        xs.delete(); lit.delete();
        xs.push_back(3);
        lit.push_back(32'hFFFF_FFFD);
        directed("neg_tap", xs, lit);

        xs.delete();
        run_frame("zero_len", xs, 0, 0);
        chk("zero_len_outs", 32'(got.size()), 0);

        set_taps(1);
        xs.delete(); lit.delete();
        xs.push_back(7); xs.push_back(8);
        lit.push_back(7); lit.push_back(15);
        hold = 5;
        stall_cnt = 0;
        directed("backpressure", xs, lit);
        chk("backpressure_stall", 32'(stall_cnt >= 5), 1);

        xs.delete();
        for (int i = 1; i <= 5; i++) xs.push_back(i);
        q_in = xs;
        drv_en = 1;
        data_length = 5;
        ap_start = 1;
        @(negedge axis_clk);
        ap_start = 0;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge axis_clk);
            if (tap_EN && data_WE == 4'h0) begin
                ok = 1;
                break;
            end
        end
        chk("midreset_reach_mac", 32'(ok), 1);
        #1 axis_rst_n = 0;
        #1 chk_reset_outs("midreset");
        drv_en = 0;
        q_in.delete();
        exp_d.delete();
        exp_l.delete();
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1;
        lit.delete(); s = 0;
        for (int i = 1; i <= 5; i++) begin
            s += i;
            lit.push_back(s);
        end
        directed("after_reset", xs, lit);

        for (int r = 0; r < 8; r++) begin
            foreach (tap_mem[i]) tap_mem[i] = r[0] ? $urandom : 32'(int'($urandom_range(0, 16)) - 8);
            len = $urandom_range(1, 30);
            xs.delete();
            for (int i = 0; i < len; i++) xs.push_back(r[1] ? $urandom : 32'(int'($urandom_range(0, 200)) - 100));
            vprob = $urandom_range(30, 100);
            rprob = $urandom_range(30, 100);
            run_frame($sformatf("rand%0d", r), xs, len, 1);
            chk($sformatf("rand%0d_outs", r), 32'(got.size()), 32'(len));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
